// File: rtl/booth_mult32_pkg.sv
// Shared ALU package: datapath width, multiplier FSM encoding and the
// accumulator adder used by the Booth step.
package booth_mult32_pkg;

    localparam int unsigned WIDTH = 32;

    // Booth accumulator: one guard bit above the operand width
    localparam int unsigned ACC_W = WIDTH + 1;

    // Product register: accumulator, multiplier and Booth guard bit
    localparam int unsigned PROD_W = ACC_W + WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Accumulator adder with carry-in; subtraction is a + ~b + 1
    function automatic logic [ACC_W-1:0] acc_add(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b,
        input logic             cin
    );
        return a + b + ACC_W'(cin);
    endfunction

endpackage

// File: rtl/booth_mult32_booth_step.sv
// One radix-2 Booth iteration: recode P[1:0], add/subtract the
// multiplicand into the accumulator, then arithmetic shift P right by 1.
//   p        : current product register {acc, multiplier, guard}
//   m        : sign-extended multiplicand
//   p_next_c : product register after this iteration (combinational)
module booth_step
    import booth_mult32_pkg::*;
(
    input  logic [PROD_W-1:0] p,
    input  logic [ACC_W-1:0]  m,
    output logic [PROD_W-1:0] p_next_c
);

    logic             do_op;
    logic             do_sub;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] acc_new;

    // Recode on {multiplier LSB, guard}: 01 adds M, 10 subtracts M
    always_comb begin
        do_op    = p[1] ^ p[0];
        do_sub   = p[1] & ~p[0];
        acc      = p[PROD_W-1:WIDTH+1];
        addend   = do_sub ? ~m : m;
        sum      = acc_add(acc, addend, do_sub);
        acc_new  = do_op ? sum : acc;
        // Arithmetic right shift: replicate the accumulator sign bit
        p_next_c = {acc_new[ACC_W-1], acc_new, p[WIDTH:1]};
    end

endmodule

// File: rtl/booth_mult32.sv
// Iterative 32-bit signed multiplier, radix-2 Booth, one step per clock.
// Returns the low 32 bits of A*B, an overflow flag and a one-cycle ready.
//   clock, reset     : clock and synchronous active-high reset
//   ctrl_MULT        : start pulse; operands sampled on this edge
//   data_operandA/B  : signed multiplicand / multiplier
//   data_result      : low WIDTH bits of the product (registered)
//   data_exception   : product does not fit in signed WIDTH bits
//   data_resultRDY   : one-cycle pulse marking result/exception valid
module booth_mult32
    import booth_mult32_pkg::*;
#(
    parameter int unsigned WIDTH = booth_mult32_pkg::WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int unsigned P_W = 2 * WIDTH + 2;
    localparam int unsigned M_W = WIDTH + 1;

    mult_state_t      state;
    logic [P_W-1:0]   p;
    logic [M_W-1:0]   m;
    logic [CNT_W-1:0] cnt;
    logic [P_W-1:0]   p_next_c;
    logic             last_iter_c;
    logic             overflow_c;

    booth_step u_step (
        .p        (p),
        .m        (m),
        .p_next_c (p_next_c)
    );

    // 64-bit product is p_next[2W:1]; it fits iff the upper half is all sign
    assign last_iter_c = (cnt == CNT_W'(WIDTH - 1));
    assign overflow_c  = (p_next_c[2*WIDTH:WIDTH+1] != {WIDTH{p_next_c[WIDTH]}});

    // FSM, datapath registers and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            p              <= '0;
            m              <= '0;
            cnt            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else if (ctrl_MULT) begin
            // Start wins over any in-flight operation
            state          <= RUN;
            p              <= {M_W'(0), data_operandB, 1'b0};
            m              <= {data_operandA[WIDTH-1], data_operandA};
            cnt            <= '0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                RUN: begin
                    p   <= p_next_c;
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter_c) begin
                        state          <= DONE;
                        data_result    <= p_next_c[WIDTH:1];
                        data_exception <= overflow_c;
                        data_resultRDY <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult32.sv
// Directed bench for booth_mult32: a vector table of signed products with
// hand-computed low words and overflow flags, plus restart, back-to-back
// and reset sequences.
module tb_booth_mult32;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_vec;
    int n_fail;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];

    booth_mult32 dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Drive a start pulse; returns #1 after the sampling edge
    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Count edges until the ready pulse; returns #1 after the edge that raised it
    task automatic wait_rdy(input string name, input int lat);
        int first;
        first = 0;
        for (int c = 1; c <= lat + 8; c++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                first = c;
                break;
            end
        end
        chk({name, " latency"}, 32'(first), 32'(lat));
    endtask

    // Expect no ready pulse for a number of cycles
    task automatic expect_no_rdy(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen++;
        end
        chk({name, " no rdy"}, 32'(seen), 32'd0);
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;

        //          a              b              low word       exc
        vecs[0]  = '{32'h00000003, 32'h00000005, 32'h0000000F, 1'b0};
        vecs[1]  = '{32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6, 1'b0};
        vecs[2]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[3]  = '{32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
        vecs[4]  = '{32'h80000000, 32'h00000001, 32'h80000000, 1'b0};
        vecs[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        vecs[6]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b1};
        vecs[7]  = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
        vecs[8]  = '{32'h00000000, 32'h12345678, 32'h00000000, 1'b0};
        vecs[9]  = '{32'h00012345, 32'h00000100, 32'h01234500, 1'b0};
        vecs[10] = '{32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b1};
        vecs[11] = '{32'h0000B505, 32'h0000B505, 32'h80001219, 1'b1};
        vecs[12] = '{32'h0000B504, 32'h0000B504, 32'h7FFEA810, 1'b0};

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset result", data_result, 32'd0);
        chk("reset exc", 32'(data_exception), 32'd0);
        chk("reset rdy", 32'(data_resultRDY), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Vector table
        for (int i = 0; i < NVEC; i++) begin
            pulse_start(vecs[i].a, vecs[i].b);
            wait_rdy($sformatf("vec%0d", i), 32);
            chk($sformatf("vec%0d result", i), data_result, vecs[i].res);
            chk($sformatf("vec%0d exc", i), 32'(data_exception), 32'(vecs[i].exc));
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d rdy width", i), 32'(data_resultRDY), 32'd0);
            chk($sformatf("vec%0d hold", i), data_result, vecs[i].res);
        end

        // Restart at iteration 10 aborts the first operation
        pulse_start(32'd3, 32'd5);
        repeat (9) @(posedge clock);
        pulse_start(32'd2, 32'd2);
        wait_rdy("restart", 32);
        chk("restart result", data_result, 32'h00000004);
        chk("restart exc", 32'(data_exception), 32'd0);
        expect_no_rdy("restart tail", 40);

        // Back-to-back: new start in the ready cycle
        pulse_start(32'h80000000, 32'hFFFFFFFF);
        wait_rdy("b2b first", 32);
        chk("b2b first result", data_result, 32'h80000000);
        chk("b2b first exc", 32'(data_exception), 32'd1);
        pulse_start(32'd4, 32'd4);
        chk("b2b rdy width", 32'(data_resultRDY), 32'd0);
        chk("b2b hold", data_result, 32'h80000000);
        wait_rdy("b2b second", 32);
        chk("b2b second result", data_result, 32'h00000010);
        chk("b2b second exc", 32'(data_exception), 32'd0);

        // Reset mid-RUN clears outputs and suppresses the ready pulse
        pulse_start(32'd9, 32'd7);
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst result", data_result, 32'd0);
        chk("midrst exc", 32'(data_exception), 32'd0);
        chk("midrst rdy", 32'(data_resultRDY), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        expect_no_rdy("midrst", 40);
        pulse_start(32'd4, 32'd4);
        wait_rdy("post reset", 32);
        chk("post reset result", data_result, 32'h00000010);

        // Reset together with a start drops the start
        @(negedge clock);
        reset         = 1'b1;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd7;
        data_operandB = 32'd7;
        @(posedge clock);
        #1;
        chk("rst+start result", data_result, 32'd0);
        @(negedge clock);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        expect_no_rdy("rst+start", 40);
        chk("rst+start hold", data_result, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
